// File: rtl/simon_control.sv
// Simon game sequencer: steps the datapath through record, playback, repeat-check and end-of-game.
// Strobes are decoded combinationally from the state and the datapath flags; LED outputs depend on the state only.
module simon_control #(
    parameter int unsigned PLAY_TICKS = 50_000_000,
    parameter int unsigned TIMER_W    = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       advance,
    input  logic       legal,
    input  logic       i_eq_ns,
    input  logic       right_guess,
    input  logic       ns_full,
    output logic       mem_we,
    output logic       count_ns,
    output logic       rst_i,
    output logic       count_i,
    output logic       led_src,
    output logic [2:0] mode_leds
);

    typedef enum logic [1:0] {
        S_INPUT,
        S_PLAYBACK,
        S_REPEAT,
        S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 step;

    assign step = (timer_q == TIMER_W'(PLAY_TICKS - 1));

    // The timer idles at zero outside PLAYBACK/DONE, so every entry into those states starts a fresh step.
    always_comb begin
        state_d  = state_q;
        timer_d  = '0;
        mem_we   = 1'b0;
        count_ns = 1'b0;
        rst_i    = 1'b0;
        count_i  = 1'b0;
        if (reset) begin
            case (state_q)
                S_INPUT: begin
                    if (advance && legal) begin
                        mem_we   = 1'b1;
                        count_ns = 1'b1;
                        rst_i    = 1'b1;
                        state_d  = S_PLAYBACK;
                    end
                end
                S_PLAYBACK: begin
                    timer_d = step ? '0 : timer_q + TIMER_W'(1);
                    if (step) begin
                        if (i_eq_ns) begin
                            rst_i   = 1'b1;
                            state_d = S_REPEAT;
                            timer_d = '0;
                        end else begin
                            count_i = 1'b1;
                        end
                    end
                end
                S_REPEAT: begin
                    if (advance) begin
                        if (!right_guess) begin
                            rst_i   = 1'b1;
                            state_d = S_DONE;
                        end else if (!i_eq_ns) begin
                            count_i = 1'b1;
                        end else begin
                            rst_i   = 1'b1;
                            state_d = ns_full ? S_DONE : S_INPUT;
                        end
                    end
                end
                S_DONE: begin
                    timer_d = step ? '0 : timer_q + TIMER_W'(1);
                    if (step) begin
                        if (i_eq_ns) begin
                            rst_i = 1'b1;
                        end else begin
                            count_i = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        led_src   = 1'b0;
        mode_leds = 3'b001;
        case (state_q)
            S_INPUT:    begin led_src = 1'b0; mode_leds = 3'b001; end
            S_PLAYBACK: begin led_src = 1'b1; mode_leds = 3'b010; end
            S_REPEAT:   begin led_src = 1'b0; mode_leds = 3'b100; end
            S_DONE:     begin led_src = 1'b1; mode_leds = 3'b111; end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_INPUT;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

endmodule
